// File: rtl/cola_writeback_pkg.sv
// Shared types and sizes for the write-back queue in front of banco_registros.
package cola_writeback_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam int REG_W         = 5;
  localparam int DATA_W        = 32;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/cola_writeback_buscador_fwd.sv
// Youngest-match search over queued writes for one decode read port.
// Search logic only exists when COLA_WRITEBACK_FORWARD_EN is defined; otherwise outputs are 0.
module buscador_fwd
  import cola_writeback_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  wb_entry_t                  entries [DEPTH],
  input  logic [DEPTH-1:0]           occ,
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [REG_W-1:0]           index,
  output logic                       hit,
  output logic [DATA_W-1:0]          data
);

  localparam int PTR_W = $clog2(DEPTH);

`ifdef COLA_WRITEBACK_FORWARD_EN
  logic [PTR_W-1:0] idx;
  logic             match;

  // Walk oldest to youngest from head so the last match seen is the youngest.
  always_comb begin
    hit   = 1'b0;
    data  = {DATA_W{1'b0}};
    idx   = {PTR_W{1'b0}};
    match = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx   = head + PTR_W'(k);
      match = occ[idx] && (index != {REG_W{1'b0}}) && (entries[idx].rd == index);
      hit   = hit | match;
      data  = match ? entries[idx].data : data;
    end
  end
`else
  logic unused_ok;

  always_comb begin
    unused_ok = ^{occ, head, index};
    for (int k = 0; k < DEPTH; k++) begin
      unused_ok = unused_ok ^ (^entries[k]);
    end
  end

  assign hit  = 1'b0;
  assign data = {DATA_W{1'b0}};
`endif

endmodule

// File: rtl/cola_writeback.sv
// Write-back FIFO that queues register writes until the register-file port is granted.
// Optional forwarding of pending writes to decode is enabled by COLA_WRITEBACK_FORWARD_EN.
module cola_writeback
  import cola_writeback_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              rf_grant,
  output logic              RegWrite,
  output logic [REG_W-1:0]  writeReg,
  output logic [DATA_W-1:0] writeData,
  input  logic [REG_W-1:0]  readReg1,
  input  logic [REG_W-1:0]  readReg2,
  output logic              fwdHit1,
  output logic              fwdHit2,
  output logic [DATA_W-1:0] fwdData1,
  output logic [DATA_W-1:0] fwdData2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             nonempty;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] occ;

  // Readiness comes from registered count only, so a pop never frees a slot in the same cycle.
  assign nonempty  = (count != {CNT_W{1'b0}});
  assign wb_ready  = (count < FULL);
  assign push      = wb_valid && wb_ready && (wb_rd != {REG_W{1'b0}});
  assign pop       = rf_grant && nonempty;
  assign RegWrite  = pop;
  assign writeReg  = nonempty ? mem[head].rd   : {REG_W{1'b0}};
  assign writeData = nonempty ? mem[head].data : {DATA_W{1'b0}};

  // Entry storage; occupancy decides visibility so no reset is needed here.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[tail] <= {wb_rd, wb_data};
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      head  <= {PTR_W{1'b0}};
      tail  <= {PTR_W{1'b0}};
      count <= {CNT_W{1'b0}};
    end else begin
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Slot i is occupied when its distance from head is below count.
  always_comb begin
    occ = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      occ[i] = ({1'b0, PTR_W'(i) - head} < count);
    end
  end

  buscador_fwd #(.DEPTH(DEPTH)) u_fwd1 (
    .entries (mem),
    .occ     (occ),
    .head    (head),
    .index   (readReg1),
    .hit     (fwdHit1),
    .data    (fwdData1)
  );

  buscador_fwd #(.DEPTH(DEPTH)) u_fwd2 (
    .entries (mem),
    .occ     (occ),
    .head    (head),
    .index   (readReg2),
    .hit     (fwdHit2),
    .data    (fwdData2)
  );

endmodule

// File: doc/cola_writeback.md
COLA_WRITEBACK -- requirements
Module: cola_writeback

Interface
REQ-001 Parameter: DEPTH, default 4, number of queued register writes (power of two, >=2).
REQ-002 Port: CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 Port: RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: wb_valid  input  1  producer offers a write this cycle.
REQ-005 Port: wb_rd  input  5  destination register index of offered write.
REQ-006 Port: wb_data  input  32  data of offered write.
REQ-007 Port: wb_ready  output  1  queue accepts an offer this cycle.
REQ-008 Port: rf_grant  input  1  register-file write port available this cycle.
REQ-009 Port: RegWrite  output  1  write enable to banco_registros.
REQ-010 Port: writeReg  output  5  index to banco_registros.
REQ-011 Port: writeData  output  32  data to banco_registros.
REQ-012 Port: readReg1, readReg2  input  5 each  decode-stage read indices.
REQ-013 Port: fwdHit1, fwdHit2  output  1 each  pending write matches readRegN.
REQ-014 Port: fwdData1, fwdData2  output  32 each  youngest pending data for readRegN.

Function
REQ-015 The block SHALL be a FIFO of DEPTH {rd, data} entries with head, tail and a count of width clog2(DEPTH)+1, with head and tail wrapping modulo DEPTH.
REQ-016 wb_ready SHALL equal (count < DEPTH), derived from registered count only; a same-cycle pop SHALL NOT raise wb_ready when full.
REQ-017 Push occurs when wb_valid && wb_ready; a push with wb_rd == 0 SHALL be accepted and discarded, leaving count unchanged.
REQ-018 RegWrite SHALL equal rf_grant && (count != 0); a pop occurs exactly when RegWrite is 1.
REQ-019 writeReg/writeData SHALL present the head entry whenever count != 0, and 0/0 when empty.
REQ-020 Latency: a push into an empty queue SHALL reach RegWrite no earlier than the next cycle; no same-cycle pass-through.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve order, including wrap-around of both pointers.
REQ-022 Entries SHALL drain strictly in push order, one per granted cycle; rf_grant low SHALL hold all state.
REQ-023 Forwarding: fwdHitN SHALL be 1 when any occupied entry has rd == readRegN != 0; fwdDataN SHALL be the data of the youngest matching entry, else 0.
REQ-024 The head entry being popped in the current cycle SHALL still be eligible for forwarding; the same-cycle incoming offer SHALL NOT be forwarded.

Reset
REQ-025 RESET_N low SHALL immediately clear head, tail and count and force RegWrite=0, writeReg=0, writeData=0, fwdHit1/2=0, fwdData1/2=0, wb_ready=1.
REQ-026 Reset asserted mid-operation SHALL discard all pending entries; no partial write SHALL reach banco_registros.
REQ-027 Entry storage contents need no reset; occupancy alone determines visibility.

Configuration
REQ-028 Macro COLA_WRITEBACK_FORWARD_EN: when defined, REQ-023/REQ-024 forwarding logic SHALL be built.
REQ-029 Without COLA_WRITEBACK_FORWARD_EN, fwdHit1/2 and fwdData1/2 SHALL be tied to 0 and no search logic synthesized; queue behaviour is otherwise identical.

Structure
REQ-030 Package cola_writeback_pkg SHALL hold DEPTH default, REG_W=5, DATA_W=32 and the entry typedef {rd, data}.
REQ-031 The forwarding search SHALL be sub-module buscador_fwd (entries, occupancy mask, age order, index in -> hit, data out), instantiated once per read port.

Verification
REQ-032 Push rd=5/0xDEADBEEF with rf_grant=1 on empty -> next cycle RegWrite=1, writeReg=5, writeData=0xDEADBEEF; count returns to 0.
REQ-033 rf_grant=0, push 4 writes (rd 1..4) -> wb_ready=0 after 4th; fifth offer held; grant one cycle -> rd 1 written, wb_ready=1 the following cycle.
REQ-034 Queue rd=7/0x11 then rd=7/0x22, readReg1=7 -> fwdHit1=1, fwdData1=0x22; readReg2=0 -> fwdHit2=0.
REQ-035 Push wb_rd=0 with wb_valid=1 -> wb_ready=1, count unchanged, RegWrite never asserted for it.
REQ-036 Continuous push and grant across 10 writes -> order preserved through pointer wrap; RESET_N pulsed low with 3 pending -> outputs 0 at once, no further RegWrite.
